// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC issue controller and the MAC itself.
package mac_pkg;

  localparam int unsigned MAC_DATA_WIDTH = 32;
  localparam int unsigned MAC_LEN_W      = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

endpackage : mac_pkg

// File: rtl/mac_issue_ctrl_if.sv
// Job, operand-pair, MAC start/done and result signals of the MAC issue controller.
interface mac_issue_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_W      = 8
) ();

  logic                  job_valid_i;
  logic                  job_ready_o;
  logic [LEN_W-1:0]      job_len_i;
  logic                  pair_valid_i;
  logic                  pair_ready_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] weight_i;
  logic                  mac_start_o;
  logic [DATA_WIDTH-1:0] mac_data_o;
  logic [DATA_WIDTH-1:0] mac_weight_o;
  logic                  mac_done_i;
  logic [DATA_WIDTH-1:0] mac_result_i;
  logic                  res_valid_o;
  logic                  res_ready_i;
  logic [DATA_WIDTH-1:0] res_data_o;
  logic                  res_err_o;
  logic                  busy_o;

  // Controller side
  modport master (
    input  job_valid_i, job_len_i, pair_valid_i, data_i, weight_i,
           mac_done_i, mac_result_i, res_ready_i,
    output job_ready_o, pair_ready_o, mac_start_o, mac_data_o, mac_weight_o,
           res_valid_o, res_data_o, res_err_o, busy_o
  );

  // Environment side (job source, operand buffers, MAC, result sink)
  modport slave (
    output job_valid_i, job_len_i, pair_valid_i, data_i, weight_i,
           mac_done_i, mac_result_i, res_ready_i,
    input  job_ready_o, pair_ready_o, mac_start_o, mac_data_o, mac_weight_o,
           res_valid_o, res_data_o, res_err_o, busy_o
  );

endinterface : mac_issue_ctrl_if

// File: rtl/mac_issue_ctrl.sv
// Issues N operand pairs to one MAC via start/done, then returns the MAC's running result.
// Optional MAC_WDOG_EN: S_WAIT watchdog that ends the job with res_err_o after TIMEOUT_CYC cycles.
module mac_issue_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = MAC_DATA_WIDTH,
  parameter int unsigned LEN_W       = MAC_LEN_W
`ifdef MAC_WDOG_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  mac_issue_ctrl_if.master bus
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_W-1:0]      r_remaining;
  logic [LEN_W-1:0]      w_remaining_nxt;
  logic [DATA_WIDTH-1:0] r_mac_data;
  logic [DATA_WIDTH-1:0] w_mac_data_nxt;
  logic [DATA_WIDTH-1:0] r_mac_weight;
  logic [DATA_WIDTH-1:0] w_mac_weight_nxt;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic [DATA_WIDTH-1:0] w_res_data_nxt;
  logic                  r_job_ready;
  logic                  r_pair_ready;
  logic                  r_mac_start;
  logic                  r_res_valid;
  logic                  r_busy;

`ifdef MAC_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);

  logic [WDOG_W-1:0]     r_wdog;
  logic [WDOG_W-1:0]     w_wdog_nxt;
  logic                  r_res_err;
  logic                  w_res_err_nxt;
`endif

  // Next-state and datapath updates
  always_comb begin
    w_state_nxt      = r_state;
    w_remaining_nxt  = r_remaining;
    w_mac_data_nxt   = r_mac_data;
    w_mac_weight_nxt = r_mac_weight;
    w_res_data_nxt   = r_res_data;
`ifdef MAC_WDOG_EN
    w_wdog_nxt       = r_wdog;
    w_res_err_nxt    = r_res_err;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (bus.job_valid_i && r_job_ready) begin
          w_remaining_nxt = bus.job_len_i;
`ifdef MAC_WDOG_EN
          w_res_err_nxt   = 1'b0;
`endif
          if (bus.job_len_i == '0) begin
            w_res_data_nxt = '0;
            w_state_nxt    = S_OUT;
          end else begin
            w_state_nxt    = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        if (bus.pair_valid_i && r_pair_ready) begin
          w_mac_data_nxt   = bus.data_i;
          w_mac_weight_nxt = bus.weight_i;
          w_state_nxt      = S_ISSUE;
        end
      end

      S_ISSUE: begin
`ifdef MAC_WDOG_EN
        w_wdog_nxt  = '0;
`endif
        w_state_nxt = S_WAIT;
      end

      // remaining is at least 1 here, so the decrement cannot wrap
      S_WAIT: begin
        if (bus.mac_done_i) begin
          w_res_data_nxt  = bus.mac_result_i;
          w_remaining_nxt = r_remaining - LEN_W'(1);
          w_state_nxt     = (r_remaining == LEN_W'(1)) ? S_OUT : S_FETCH;
        end
`ifdef MAC_WDOG_EN
        else if (r_wdog == WDOG_W'(TIMEOUT_CYC - 1)) begin
          w_res_err_nxt   = 1'b1;
          w_remaining_nxt = '0;
          w_state_nxt     = S_OUT;
        end else begin
          w_wdog_nxt      = r_wdog + WDOG_W'(1);
        end
`endif
      end

      S_OUT: begin
        if (bus.res_ready_i && r_res_valid) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and Moore outputs registered from the next state
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state      <= S_IDLE;
      r_remaining  <= '0;
      r_mac_data   <= '0;
      r_mac_weight <= '0;
      r_res_data   <= '0;
      r_job_ready  <= 1'b0;
      r_pair_ready <= 1'b0;
      r_mac_start  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_busy       <= 1'b0;
`ifdef MAC_WDOG_EN
      r_wdog       <= '0;
      r_res_err    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_remaining_nxt;
      r_mac_data   <= w_mac_data_nxt;
      r_mac_weight <= w_mac_weight_nxt;
      r_res_data   <= w_res_data_nxt;
      r_job_ready  <= (w_state_nxt == S_IDLE);
      r_pair_ready <= (w_state_nxt == S_FETCH);
      r_mac_start  <= (w_state_nxt == S_ISSUE);
      r_res_valid  <= (w_state_nxt == S_OUT);
      r_busy       <= (w_state_nxt != S_IDLE);
`ifdef MAC_WDOG_EN
      r_wdog       <= w_wdog_nxt;
      r_res_err    <= w_res_err_nxt;
`endif
    end
  end

  assign bus.job_ready_o  = r_job_ready;
  assign bus.pair_ready_o = r_pair_ready;
  assign bus.mac_start_o  = r_mac_start;
  assign bus.mac_data_o   = r_mac_data;
  assign bus.mac_weight_o = r_mac_weight;
  assign bus.res_valid_o  = r_res_valid;
  assign bus.res_data_o   = r_res_data;
  assign bus.busy_o       = r_busy;
`ifdef MAC_WDOG_EN
  assign bus.res_err_o    = r_res_err;
`else
  assign bus.res_err_o    = 1'b0;
`endif

endmodule : mac_issue_ctrl
